// File: rtl/mc_cu.sv
// mc_cu: multi-cycle MIPS control unit (IF/ID/EXE/MEM/WB) driving a shared-ALU,
// single-memory datapath with a req/rdy handshake to unified memory.
// Only the state is registered. Every control output is decoded from the state
// and op/func/z/mem_rdy, and is forced to 0 while resetn is low.
// Optional feature: define MC_CU_ILLEGAL_TRAP_EN to trap undefined
// instructions in a HALT state that asserts illegal until reset.
module mc_cu (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       iord,
  output logic       wmem,
  output logic       wir,
  output logic       wpc,
  output logic       wreg,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       sext,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b101
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  state_t state_r, state_next_s;

  // Instruction class flags and ALU operation decoded from the IR fields.
  logic       i_alu_r_s, i_shift_s, i_jr_s, i_alu_i_s, i_addi_s;
  logic       i_lw_s, i_sw_s, i_beq_s, i_bne_s, i_j_s, i_jal_s, i_undef_s;
  logic [3:0] alu_op_s;

  // Control outputs before reset gating.
  logic       mem_req_s, iord_s, wmem_s, wir_s, wpc_s, wreg_s, regrt_s, m2reg_s;
  logic       jal_s, shift_s, sext_s, alusrca_s, illegal_s;
  logic [1:0] alusrcb_s, pcsource_s;
  logic [3:0] aluc_s;

  // Instruction decode: classify op/func and select the ALU operation.
  always_comb begin
    i_alu_r_s = 1'b0;
    i_shift_s = 1'b0;
    i_jr_s    = 1'b0;
    i_alu_i_s = 1'b0;
    i_addi_s  = 1'b0;
    i_lw_s    = 1'b0;
    i_sw_s    = 1'b0;
    i_beq_s   = 1'b0;
    i_bne_s   = 1'b0;
    i_j_s     = 1'b0;
    i_jal_s   = 1'b0;
    alu_op_s  = ALU_ADD;
    case (op)
      6'b000000: begin
        case (func)
          6'b100000: begin i_alu_r_s = 1'b1; alu_op_s = ALU_ADD; end
          6'b100010: begin i_alu_r_s = 1'b1; alu_op_s = ALU_SUB; end
          6'b100100: begin i_alu_r_s = 1'b1; alu_op_s = ALU_AND; end
          6'b100101: begin i_alu_r_s = 1'b1; alu_op_s = ALU_OR;  end
          6'b100110: begin i_alu_r_s = 1'b1; alu_op_s = ALU_XOR; end
          6'b000000: begin i_alu_r_s = 1'b1; i_shift_s = 1'b1; alu_op_s = ALU_SLL; end
          6'b000010: begin i_alu_r_s = 1'b1; i_shift_s = 1'b1; alu_op_s = ALU_SRL; end
          6'b000011: begin i_alu_r_s = 1'b1; i_shift_s = 1'b1; alu_op_s = ALU_SRA; end
          6'b001000: i_jr_s = 1'b1;
          default:   alu_op_s = ALU_ADD;
        endcase
      end
      6'b001000: begin i_alu_i_s = 1'b1; i_addi_s = 1'b1; alu_op_s = ALU_ADD; end
      6'b001100: begin i_alu_i_s = 1'b1; alu_op_s = ALU_AND; end
      6'b001101: begin i_alu_i_s = 1'b1; alu_op_s = ALU_OR;  end
      6'b001110: begin i_alu_i_s = 1'b1; alu_op_s = ALU_XOR; end
      6'b001111: begin i_alu_i_s = 1'b1; alu_op_s = ALU_LUI; end
      6'b100011: i_lw_s  = 1'b1;
      6'b101011: i_sw_s  = 1'b1;
      6'b000100: i_beq_s = 1'b1;
      6'b000101: i_bne_s = 1'b1;
      6'b000010: i_j_s   = 1'b1;
      6'b000011: i_jal_s = 1'b1;
      default:   alu_op_s = ALU_ADD;
    endcase
    i_undef_s = ~(i_alu_r_s | i_jr_s | i_alu_i_s | i_lw_s | i_sw_s |
                  i_beq_s | i_bne_s | i_j_s | i_jal_s);
  end

  // State register; reset returns to IF and abandons any memory access.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IF;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_next_s = state_r;
    mem_req_s  = 1'b0;
    iord_s     = 1'b0;
    wmem_s     = 1'b0;
    wir_s      = 1'b0;
    wpc_s      = 1'b0;
    wreg_s     = 1'b0;
    regrt_s    = 1'b0;
    m2reg_s    = 1'b0;
    jal_s      = 1'b0;
    shift_s    = 1'b0;
    sext_s     = 1'b0;
    alusrca_s  = 1'b0;
    illegal_s  = 1'b0;
    alusrcb_s  = 2'b00;
    pcsource_s = 2'b00;
    aluc_s     = ALU_ADD;
    case (state_r)
      ST_IF: begin
        // PC + 4 is computed every fetch cycle but only written once the word arrives.
        mem_req_s = 1'b1;
        alusrcb_s = 2'b01;
        if (mem_rdy) begin
          wir_s        = 1'b1;
          wpc_s        = 1'b1;
          state_next_s = ST_ID;
        end else begin
          state_next_s = ST_IF;
        end
      end
      ST_ID: begin
        // The ALU computes the branch target speculatively for EXE.
        alusrcb_s = 2'b11;
        sext_s    = 1'b1;
        if (i_j_s | i_jal_s) begin
          wpc_s        = 1'b1;
          pcsource_s   = 2'b11;
          wreg_s       = i_jal_s;
          jal_s        = i_jal_s;
          state_next_s = ST_IF;
        end else if (i_jr_s) begin
          wpc_s        = 1'b1;
          pcsource_s   = 2'b10;
          state_next_s = ST_IF;
        end else if (i_undef_s) begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
          state_next_s = ST_HALT;
`else
          state_next_s = ST_IF;
`endif
        end else begin
          state_next_s = ST_EXE;
        end
      end
      ST_EXE: begin
        alusrca_s = 1'b1;
        if (i_alu_r_s) begin
          shift_s      = i_shift_s;
          aluc_s       = alu_op_s;
          state_next_s = ST_WB;
        end else if (i_alu_i_s) begin
          alusrcb_s    = 2'b10;
          sext_s       = i_addi_s;
          aluc_s       = alu_op_s;
          state_next_s = ST_WB;
        end else if (i_lw_s | i_sw_s) begin
          alusrcb_s    = 2'b10;
          sext_s       = 1'b1;
          state_next_s = ST_MEM;
        end else begin
          aluc_s = ALU_SUB;
          if ((i_beq_s & z) | (i_bne_s & ~z)) begin
            wpc_s      = 1'b1;
            pcsource_s = 2'b01;
          end else begin
            wpc_s      = 1'b0;
          end
          state_next_s = ST_IF;
        end
      end
      ST_MEM: begin
        // Outputs hold steady across wait cycles; the store commits in the rdy cycle.
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        wmem_s    = i_sw_s;
        if (mem_rdy) begin
          state_next_s = i_lw_s ? ST_WB : ST_IF;
        end else begin
          state_next_s = ST_MEM;
        end
      end
      ST_WB: begin
        wreg_s       = 1'b1;
        regrt_s      = i_alu_i_s | i_lw_s;
        m2reg_s      = i_lw_s;
        state_next_s = ST_IF;
      end
`ifdef MC_CU_ILLEGAL_TRAP_EN
      ST_HALT: begin
        illegal_s    = 1'b1;
        state_next_s = ST_HALT;
      end
`endif
      default: begin
        state_next_s = ST_IF;
      end
    endcase
  end

  // Every output reads 0 while reset is held, independent of the datapath.
  assign mem_req  = mem_req_s  & resetn;
  assign iord     = iord_s     & resetn;
  assign wmem     = wmem_s     & resetn;
  assign wir      = wir_s      & resetn;
  assign wpc      = wpc_s      & resetn;
  assign wreg     = wreg_s     & resetn;
  assign regrt    = regrt_s    & resetn;
  assign m2reg    = m2reg_s    & resetn;
  assign jal      = jal_s      & resetn;
  assign shift    = shift_s    & resetn;
  assign sext     = sext_s     & resetn;
  assign alusrca  = alusrca_s  & resetn;
  assign illegal  = illegal_s  & resetn;
  assign alusrcb  = alusrcb_s  & {2{resetn}};
  assign pcsource = pcsource_s & {2{resetn}};
  assign aluc     = aluc_s     & {4{resetn}};
  assign state    = state_r    & {3{resetn}};

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: table-driven check of the mc_cu per-cycle control word, plus
// hand-written reset-in-MEM and undefined-instruction sequences.
module tb_mc_cu;

  logic       clock = 1'b0;
  logic       resetn;
  logic [5:0] op, func;
  logic       z, mem_rdy;
  logic       mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal, shift, sext;
  logic       alusrca, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;

  mc_cu dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .iord(iord), .wmem(wmem), .wir(wir), .wpc(wpc), .wreg(wreg),
    .regrt(regrt), .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource),
    .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  // Control word layout: {mem_req,iord,wmem,wir,wpc,wreg,regrt,m2reg,jal,shift,
  // sext,alusrca,alusrcb[1:0],aluc[3:0],pcsource[1:0],illegal,state[2:0]}
  logic [23:0] act;
  assign act = {mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal, shift, sext,
                alusrca, alusrcb, aluc, pcsource, illegal, state};

  localparam logic [23:0] B_MEMREQ = 24'h800000;
  localparam logic [23:0] B_IORD   = 24'h400000;
  localparam logic [23:0] B_WMEM   = 24'h200000;
  localparam logic [23:0] B_WIR    = 24'h100000;
  localparam logic [23:0] B_WPC    = 24'h080000;
  localparam logic [23:0] B_WREG   = 24'h040000;
  localparam logic [23:0] B_REGRT  = 24'h020000;
  localparam logic [23:0] B_M2REG  = 24'h010000;
  localparam logic [23:0] B_JAL    = 24'h008000;
  localparam logic [23:0] B_SHIFT  = 24'h004000;
  localparam logic [23:0] B_SEXT   = 24'h002000;
  localparam logic [23:0] B_SRCA   = 24'h001000;
  localparam logic [23:0] SRCB_4   = 24'h000400;
  localparam logic [23:0] SRCB_IMM = 24'h000800;
  localparam logic [23:0] SRCB_BR  = 24'h000C00;
  localparam logic [23:0] ALU_SUB  = 24'h000100;   // 0100 << 6
  localparam logic [23:0] ALU_OR   = 24'h000140;   // 0101 << 6
  localparam logic [23:0] ALU_LUI  = 24'h000180;   // 0110 << 6
  localparam logic [23:0] ALU_SLL  = 24'h0000C0;   // 0011 << 6
  localparam logic [23:0] ALU_SRA  = 24'h0003C0;   // 1111 << 6
  localparam logic [23:0] PCS_BR   = 24'h000010;
  localparam logic [23:0] PCS_JR   = 24'h000020;
  localparam logic [23:0] PCS_J    = 24'h000030;
  localparam logic [23:0] B_ILL    = 24'h000008;
  localparam logic [23:0] S_IF = 24'd0, S_ID = 24'd1, S_EXE = 24'd2, S_MEM = 24'd3;
  localparam logic [23:0] S_WB = 24'd4, S_HALT = 24'd5;

  localparam logic [23:0] IF_WAIT = B_MEMREQ | SRCB_4 | S_IF;
  localparam logic [23:0] IF_RDY  = IF_WAIT | B_WIR | B_WPC;
  localparam logic [23:0] ID_BASE = SRCB_BR | B_SEXT | S_ID;
  localparam logic [23:0] EXE_R   = B_SRCA | S_EXE;
  localparam logic [23:0] EXE_MEM = B_SRCA | SRCB_IMM | B_SEXT | S_EXE;
  localparam logic [23:0] EXE_BR  = B_SRCA | ALU_SUB | S_EXE;
  localparam logic [23:0] MEM_LW  = B_MEMREQ | B_IORD | S_MEM;
  localparam logic [23:0] MEM_SW  = MEM_LW | B_WMEM;
  localparam logic [23:0] WB_R    = B_WREG | S_WB;
  localparam logic [23:0] WB_I    = WB_R | B_REGRT;
  localparam logic [23:0] WB_LW   = WB_I | B_M2REG;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  func;
    logic        z;
    logic        rdy;
    logic [23:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add_vec(input logic [5:0] o, input logic [5:0] f, input logic zz,
                         input logic r, input logic [23:0] e);
    vec_t v;
    v.op = o; v.func = f; v.z = zz; v.rdy = r; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [23:0] e);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", nm, act, e);
    end
  endtask

  // Apply one cycle of inputs at a falling edge, check, then move to the next falling edge.
  task automatic step(input string nm, input logic [5:0] o, input logic [5:0] f,
                      input logic zz, input logic r, input logic [23:0] e);
    op = o; func = f; z = zz; mem_rdy = r;
    #1;
    check(nm, e);
    @(negedge clock);
  endtask

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111, OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLL = 6'b000000;
  localparam logic [5:0] F_SRA = 6'b000011, F_JR = 6'b001000, F_X = 6'b000000;

  initial begin
    // add; mem_rdy low outside IF/MEM must be ignored
    add_vec(OP_R, F_ADD, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_R, F_ADD, 1'b0, 1'b0, ID_BASE);
    add_vec(OP_R, F_ADD, 1'b1, 1'b0, EXE_R);
    add_vec(OP_R, F_ADD, 1'b0, 1'b0, WB_R);
    // lw with 2 wait cycles in IF and in MEM: 9 cycles
    add_vec(OP_LW, F_X, 1'b0, 1'b0, IF_WAIT);
    add_vec(OP_LW, F_X, 1'b0, 1'b0, IF_WAIT);
    add_vec(OP_LW, F_X, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_LW, F_X, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_LW, F_X, 1'b0, 1'b1, EXE_MEM);
    add_vec(OP_LW, F_X, 1'b0, 1'b0, MEM_LW);
    add_vec(OP_LW, F_X, 1'b0, 1'b0, MEM_LW);
    add_vec(OP_LW, F_X, 1'b0, 1'b1, MEM_LW);
    add_vec(OP_LW, F_X, 1'b0, 1'b1, WB_LW);
    // sw with 3 wait cycles in MEM, no WB
    add_vec(OP_SW, F_X, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_SW, F_X, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_SW, F_X, 1'b0, 1'b1, EXE_MEM);
    add_vec(OP_SW, F_X, 1'b0, 1'b0, MEM_SW);
    add_vec(OP_SW, F_X, 1'b0, 1'b0, MEM_SW);
    add_vec(OP_SW, F_X, 1'b0, 1'b0, MEM_SW);
    add_vec(OP_SW, F_X, 1'b0, 1'b1, MEM_SW);
    // beq taken, beq not taken, bne taken, bne not taken
    add_vec(OP_BEQ, F_X, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_BEQ, F_X, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_BEQ, F_X, 1'b1, 1'b1, EXE_BR | B_WPC | PCS_BR);
    add_vec(OP_BEQ, F_X, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_BEQ, F_X, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_BEQ, F_X, 1'b0, 1'b1, EXE_BR);
    add_vec(OP_BNE, F_X, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_BNE, F_X, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_BNE, F_X, 1'b0, 1'b1, EXE_BR | B_WPC | PCS_BR);
    add_vec(OP_BNE, F_X, 1'b1, 1'b1, IF_RDY);
    add_vec(OP_BNE, F_X, 1'b1, 1'b1, ID_BASE);
    add_vec(OP_BNE, F_X, 1'b1, 1'b1, EXE_BR);
    // jal, j, jr: two cycles each
    add_vec(OP_JAL, F_X, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_JAL, F_X, 1'b0, 1'b1, ID_BASE | B_WPC | PCS_J | B_WREG | B_JAL);
    add_vec(OP_J, F_X, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_J, F_X, 1'b0, 1'b1, ID_BASE | B_WPC | PCS_J);
    add_vec(OP_R, F_JR, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_R, F_JR, 1'b0, 1'b1, ID_BASE | B_WPC | PCS_JR);
    // sub, sll, sra
    add_vec(OP_R, F_SUB, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_R, F_SUB, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_R, F_SUB, 1'b0, 1'b1, EXE_R | ALU_SUB);
    add_vec(OP_R, F_SUB, 1'b0, 1'b1, WB_R);
    add_vec(OP_R, F_SLL, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_R, F_SLL, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_R, F_SLL, 1'b0, 1'b1, EXE_R | B_SHIFT | ALU_SLL);
    add_vec(OP_R, F_SLL, 1'b0, 1'b1, WB_R);
    add_vec(OP_R, F_SRA, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_R, F_SRA, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_R, F_SRA, 1'b0, 1'b1, EXE_R | B_SHIFT | ALU_SRA);
    add_vec(OP_R, F_SRA, 1'b0, 1'b1, WB_R);
    // addi (sign-extended), ori and lui (zero-extended)
    add_vec(OP_ADDI, F_X, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_ADDI, F_X, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_ADDI, F_X, 1'b0, 1'b1, B_SRCA | SRCB_IMM | B_SEXT | S_EXE);
    add_vec(OP_ADDI, F_X, 1'b0, 1'b1, WB_I);
    add_vec(OP_ORI, F_X, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_ORI, F_X, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_ORI, F_X, 1'b0, 1'b1, B_SRCA | SRCB_IMM | ALU_OR | S_EXE);
    add_vec(OP_ORI, F_X, 1'b0, 1'b1, WB_I);
    add_vec(OP_LUI, F_X, 1'b0, 1'b1, IF_RDY);
    add_vec(OP_LUI, F_X, 1'b0, 1'b1, ID_BASE);
    add_vec(OP_LUI, F_X, 1'b0, 1'b1, B_SRCA | SRCB_IMM | ALU_LUI | S_EXE);
    add_vec(OP_LUI, F_X, 1'b0, 1'b1, WB_I);
    // next fetch, proving lui returned to IF
    add_vec(OP_LUI, F_X, 1'b0, 1'b0, IF_WAIT);

    // Reset: all outputs 0 while resetn is low, even with mem_rdy high
    resetn = 1'b0; op = OP_SW; func = F_X; z = 1'b1; mem_rdy = 1'b1;
    @(negedge clock);
    #1; check("reset_hold", 24'h000000);
    @(negedge clock);
    #1; check("reset_hold_2", 24'h000000);
    resetn = 1'b1;

    foreach (vq[i]) begin
      step($sformatf("vec%0d", i), vq[i].op, vq[i].func, vq[i].z, vq[i].rdy, vq[i].exp);
    end

    // Reset mid-MEM of a store: wmem/mem_req drop at once, IF after release
    step("rst_sw_if",  OP_SW, F_X, 1'b0, 1'b1, IF_RDY);
    step("rst_sw_id",  OP_SW, F_X, 1'b0, 1'b1, ID_BASE);
    step("rst_sw_exe", OP_SW, F_X, 1'b0, 1'b1, EXE_MEM);
    op = OP_SW; mem_rdy = 1'b0;
    #1; check("rst_sw_mem", MEM_SW);
    #1 resetn = 1'b0;
    #1; check("rst_sw_drop", 24'h000000);
    mem_rdy = 1'b1;
    @(negedge clock);
    #1; check("rst_sw_held", 24'h000000);
    resetn = 1'b1;
    step("rst_sw_after", OP_SW, F_X, 1'b0, 1'b0, IF_WAIT);

    // Undefined instruction
    step("bad_if", OP_BAD, F_X, 1'b0, 1'b1, IF_RDY);
    step("bad_id", OP_BAD, F_X, 1'b0, 1'b1, ID_BASE);
`ifdef MC_CU_ILLEGAL_TRAP_EN
    step("halt_0", OP_BAD, F_X, 1'b0, 1'b1, B_ILL | S_HALT);
    step("halt_1", OP_R, F_ADD, 1'b0, 1'b1, B_ILL | S_HALT);
    step("halt_2", OP_R, F_ADD, 1'b0, 1'b1, B_ILL | S_HALT);
    resetn = 1'b0;
    #1; check("halt_rst", 24'h000000);
    @(negedge clock);
    resetn = 1'b1;
    step("halt_exit", OP_R, F_ADD, 1'b0, 1'b0, IF_WAIT);
`else
    step("bad_noop", OP_BAD, F_X, 1'b0, 1'b1, IF_RDY);
    step("bad_next", OP_R, F_ADD, 1'b0, 1'b1, ID_BASE);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
